reg_display_scan: RTL and testbench
===================================

// Module: reg_display_scan
// PURPOSE
//  Board-side consumer of the core's register-display port. Drives reg_out_id from two debounced
//  push-buttons, then shows the returned 32-bit reg_out_data as 8 hex digits on a multiplexed
//  7-segment display. Sits between the FPGA top wrapper pins and the Mips core.
//  Data is snapshotted once per scan frame so a frame never mixes old and new values.
// PARAMETERS
//  SCAN_DIV         50000    clock cycles each digit stays lit (>=2)
//  DEBOUNCE_CYCLES  500000   cycles a button level must be stable before it is accepted (>=2)
// PORTS
//  clock         in   1   system clock, rising edge
//  reset         in   1   asynchronous, active-low reset
//  btn_inc       in   1   raw button, 1 = pressed, asynchronous to clock
//  btn_dec       in   1   raw button, 1 = pressed, asynchronous to clock
//  reg_out_id    out  5   register index presented to the core
//  reg_out_data  in   32  register value returned by the core (combinational from reg_out_id)
//  seg_n         out  7   segments {g,f,e,d,c,b,a}, active-low
//  an_n          out  8   digit anodes, active-low, bit k = hex nibble k of the snapshot
//  dp_n          out  1   decimal point, active-low, lit only on digit 0
// BEHAVIOUR
//  Reset (reset=0, async): reg_out_id=0, snapshot=0, digit=0, scan_cnt=0, both debouncers in IDLE,
//   an_n=8'hFE, seg_n=7'h40 (glyph "0"), dp_n=0. Reset mid-press leaves the button ignored until
//   it is released and pressed again.
//  Synchroniser: each button goes through a 2-flop synchroniser before the debouncer.
//  Debouncer FSM per button: IDLE -(sync=1)-> ARM (cnt=0)
//   ARM: cnt++ while sync=1; sync=0 -> IDLE; cnt reaches DEBOUNCE_CYCLES-1 -> PRESSED
//   PRESSED: asserts a one-cycle pulse, then moves to HELD in the next cycle
//   HELD: sync=0 -> REL (cnt=0); REL: cnt++ while sync=0; sync=1 -> HELD;
//    cnt reaches DEBOUNCE_CYCLES-1 -> IDLE. Exactly one pulse per accepted press, none on release.
//  Register select, applied in the cycle after the pulse:
//   inc pulse only: reg_out_id+1, wraps 31->0; dec pulse only: reg_out_id-1, wraps 0->31
//   inc and dec pulses in the same cycle: no change.
//  Scan: scan_cnt counts 0..SCAN_DIV-1. At the wrap, digit advances 0->1->...->7->0.
//   When digit wraps 7->0, in the same edge: snapshot <= reg_out_data.
//   Also, in the cycle after reg_out_id changes: snapshot <= reg_out_data, digit<=0, scan_cnt<=0,
//   so a new selection is visible immediately.
//  Outputs are registered (one cycle after digit/snapshot update):
//   an_n = ~(8'b1 << digit); seg_n = hex glyph of snapshot[4*digit+3 -: 4]; dp_n = (digit!=0).
//   Glyphs, active-low {g..a}: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10
//   A=08 b=03 C=46 d=21 E=06 F=0E (hex).
//  Exactly one anode is low at every cycle after reset; never zero, never two.
// TESTING  (SCAN_DIV=4, DEBOUNCE_CYCLES=8)
//  1 reset low mid-run -> an_n=FE, seg_n=40, dp_n=0, reg_out_id=0 immediately, without waiting
//    for a clock edge.
//  2 reg_out_data=32'h89AB_CDEF, after one full frame -> anodes FE,FD,..,7F each for 4 cycles;
//    seg_n sequence 0E,06,21,46,03,08,10,00; dp_n=0 only with an_n=FE.
//  3 btn_inc stable high 20 cycles, then low 20 -> reg_out_id 0->1 exactly once.
//    btn_inc chattering with a 3-cycle period for 50 cycles -> no change.
//  4 reg_out_id=31, inc press -> 0. Then dec press -> 31.
//    inc and dec pulses forced in the same cycle -> reg_out_id unchanged.
//  5 reg_out_data changes from 1111_1111 to 2222_2222 while digit=3 -> digits 3..7 still show 1;
//    all digits show 2 from the next frame on.
//  6 reset asserted during ARM with button held -> no pulse, including after release of reset,
//    until the button is released and pressed again.

Source files
------------

// File: rtl/reg_display_scan_if.sv
// Register-display port between the board-side scanner and the core.
// The scanner presents a register index and the core answers combinationally
// with that register's value.
interface reg_display_scan_if;
  logic [4:0]  reg_out_id;
  logic [31:0] reg_out_data;

  // Scanner side: drives the index, reads the value back.
  modport master (
    output reg_out_id,
    input  reg_out_data
  );

  // Core side: reads the index, returns the value.
  modport slave (
    input  reg_out_id,
    output reg_out_data
  );
endinterface

// File: rtl/reg_display_scan.sv
// Board-side register viewer.
// Two debounced push-buttons step the register index shown by the core.
// The returned 32-bit value is shown as 8 hex digits on a multiplexed,
// active-low 7-segment display. The value is snapshotted once per scan frame
// and again right after a new selection, so a frame never mixes two values.
module reg_display_scan #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      btn_inc,
  input  logic                      btn_dec,
  reg_display_scan_if.master        rd,
  output logic [6:0]                seg_n,
  output logic [7:0]                an_n,
  output logic                      dp_n
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    DB_IDLE,
    DB_ARM,
    DB_PRESSED,
    DB_HELD,
    DB_REL
  } db_state_t;

  // Bit 0 = inc button, bit 1 = dec button throughout.
  logic [1:0]        sync_p0;
  logic [1:0]        sync_p1;
  db_state_t         db_state [2];
  logic [DEB_W-1:0]  db_cnt   [2];
  logic [1:0]        db_ready;
  logic [1:0]        pulse;

  logic [4:0]        reg_id;
  logic              id_chg;
  logic [31:0]       snapshot;
  logic [2:0]        digit;
  logic [SCAN_W-1:0] scan_cnt;

  assign rd.reg_out_id = reg_id;

  // Hex nibble to active-low {g,f,e,d,c,b,a} glyph.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  // Two-flop synchroniser; resets to "pressed" so a button held through
  // reset is not mistaken for a fresh press.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 2'b11;
      sync_p1 <= 2'b11;
    end else begin
      sync_p0 <= {btn_dec, btn_inc};
      sync_p1 <= sync_p0;
    end
  end

  // Debouncer FSMs: one registered pulse per accepted press. db_ready stays
  // low after reset until the button has been seen released.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        db_state[i] <= DB_IDLE;
        db_cnt[i]   <= '0;
      end
      db_ready <= 2'b00;
      pulse    <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        pulse[i] <= 1'b0;
        if (!sync_p1[i]) db_ready[i] <= 1'b1;
        case (db_state[i])
          DB_IDLE: begin
            if (sync_p1[i] && db_ready[i]) begin
              db_state[i] <= DB_ARM;
              db_cnt[i]   <= '0;
            end
          end
          DB_ARM: begin
            if (!sync_p1[i]) begin
              db_state[i] <= DB_IDLE;
            end else if (db_cnt[i] == DEB_LAST) begin
              db_state[i] <= DB_PRESSED;
              pulse[i]    <= 1'b1;
            end else begin
              db_cnt[i] <= db_cnt[i] + 1'b1;
            end
          end
          DB_PRESSED: begin
            db_state[i] <= DB_HELD;
          end
          DB_HELD: begin
            if (!sync_p1[i]) begin
              db_state[i] <= DB_REL;
              db_cnt[i]   <= '0;
            end
          end
          DB_REL: begin
            if (sync_p1[i]) begin
              db_state[i] <= DB_HELD;
            end else if (db_cnt[i] == DEB_LAST) begin
              db_state[i] <= DB_IDLE;
            end else begin
              db_cnt[i] <= db_cnt[i] + 1'b1;
            end
          end
          default: begin
            db_state[i] <= DB_IDLE;
          end
        endcase
      end
    end
  end

  // Register select: step the index on a lone pulse; simultaneous pulses cancel.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      reg_id <= 5'd0;
      id_chg <= 1'b0;
    end else begin
      id_chg <= 1'b0;
      case (pulse)
        2'b01: begin
          reg_id <= reg_id + 5'd1;
          id_chg <= 1'b1;
        end
        2'b10: begin
          reg_id <= reg_id - 5'd1;
          id_chg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Scan timing and snapshot: reload at every frame wrap, and restart the
  // frame right after a new selection so it shows up at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      snapshot <= 32'd0;
      digit    <= 3'd0;
      scan_cnt <= '0;
    end else if (id_chg) begin
      snapshot <= rd.reg_out_data;
      digit    <= 3'd0;
      scan_cnt <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      digit    <= digit + 3'd1;
      if (digit == 3'd7) snapshot <= rd.reg_out_data;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Registered display drive, one cycle behind digit/snapshot.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      an_n  <= 8'hFE;
      seg_n <= 7'h40;
      dp_n  <= 1'b0;
    end else begin
      an_n  <= ~(8'b1 << digit);
      seg_n <= hex_glyph(snapshot[{digit, 2'b00} +: 4]);
      dp_n  <= (digit != 3'd0);
    end
  end

endmodule

// File: tb/tb_reg_display_scan.sv
// Directed + randomized bench for reg_display_scan (SCAN_DIV=4, DEBOUNCE_CYCLES=8).
// The bench plays the core: reg_out_data is looked up from a register array.
// Expected display content is derived from the edge count since the last
// frame origin (reset release or a new selection).
module tb_reg_display_scan;
  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       btn_inc = 1'b0;
  logic       btn_dec = 1'b0;
  logic [6:0] seg_n;
  logic [7:0] an_n;
  logic       dp_n;
  logic [31:0] regs [32];
  int checks = 0;
  int failures = 0;
  int ek = 0;
  int org = 0;
  logic [4:0] exp_id;

  reg_display_scan_if rif ();
  assign rif.reg_out_data = regs[rif.reg_out_id];

  reg_display_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
    .clock   (clock),
    .reset   (reset),
    .btn_inc (btn_inc),
    .btn_dec (btn_dec),
    .rd      (rif),
    .seg_n   (seg_n),
    .an_n    (an_n),
    .dp_n    (dp_n)
  );

  always #5 clock = ~clock;
  always @(posedge clock) ek++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and confirm exactly one anode is lit.
  task automatic tick();
    @(negedge clock);
    check("onehot_anode", 32'($countones(~an_n)), 32'd1);
  endtask

  task automatic hold(input bit inc, input bit dec, input int n);
    btn_inc = inc;
    btn_dec = dec;
    repeat (n) tick();
  endtask

  // Go to the falling edge after edge (org + k).
  task automatic goto(input int k);
    while ((ek - org) < k) tick();
  endtask

  task automatic check_digit(input string tag, input int d, input logic [31:0] w);
    logic [7:0] ea;
    logic [3:0] nib;
    ea  = ~(8'b1 << d);
    nib = w[4*d +: 4];
    check({tag, "_an"},  32'(an_n),  32'(ea));
    check({tag, "_seg"}, 32'(seg_n), 32'(GLYPH[nib]));
    check({tag, "_dp"},  32'(dp_n),  32'(d != 0));
  endtask

  task automatic check_id(input string tag);
    check(tag, 32'(rif.reg_out_id), 32'(exp_id));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = $urandom();
    exp_id = 5'd0;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_id",  32'(rif.reg_out_id), 32'd0);
    check("rst_an",  32'(an_n),  32'hFE);
    check("rst_seg", 32'(seg_n), 32'h40);
    check("rst_dp",  32'(dp_n),  32'd0);
    reset = 1'b1;
    org = ek;

    // Frame 0 shows the reset snapshot, frame 1 the register value cycle by cycle
    regs[0] = 32'h89AB_CDEF;
    for (int d = 0; d < 8; d++) begin
      goto(2 + 4*d);
      check_digit("frame0_zero", d, 32'd0);
    end
    for (int k = 33; k <= 64; k++) begin
      goto(k);
      check_digit("frame1_scan", ((k - 1) / 4) % 8, 32'h89AB_CDEF);
    end

    // Clean press counts once; chatter is rejected
    hold(1, 0, 20);
    hold(0, 0, 20);
    exp_id = 5'd1;
    check_id("inc_once");
    for (int n = 0; n < 17; n++) begin
      hold(1, 0, 2);
      hold(0, 0, 1);
    end
    hold(0, 0, 20);
    check_id("chatter");

    // New selection appears immediately, frame restarts at digit 0
    btn_inc = 1'b1;
    org = ek + 13;
    exp_id = 5'd2;
    goto(2);
    check_digit("newsel_d0", 0, regs[2]);
    goto(20);
    btn_inc = 1'b0;
    for (int d = 5; d < 8; d++) begin
      goto(2 + 4*d);
      check_digit("newsel", d, regs[2]);
    end
    for (int d = 0; d < 8; d++) begin
      goto(34 + 4*d);
      check_digit("newsel_f1", d, regs[2]);
    end
    goto(70);
    check_id("newsel_id");

    // Data change mid-frame does not tear the frame
    regs[3] = 32'h1111_1111;
    btn_inc = 1'b1;
    org = ek + 13;
    exp_id = 5'd3;
    goto(14);
    regs[3] = 32'h2222_2222;
    goto(15);
    check_digit("tear_d3", 3, 32'h1111_1111);
    goto(20);
    btn_inc = 1'b0;
    for (int d = 4; d < 8; d++) begin
      goto(2 + 4*d);
      check_digit("tear_old", d, 32'h1111_1111);
    end
    for (int d = 0; d < 8; d++) begin
      goto(34 + 4*d);
      check_digit("tear_new", d, 32'h2222_2222);
    end
    goto(70);

    // Wrap-around in both directions, and cancelling simultaneous pulses
    for (int n = 0; n < 4; n++) begin
      hold(0, 1, 20);
      hold(0, 0, 20);
      exp_id = exp_id - 5'd1;
      check_id("dec_step");
    end
    hold(1, 0, 20);
    hold(0, 0, 20);
    exp_id = 5'd0;
    check_id("wrap_up");
    hold(0, 1, 20);
    hold(0, 0, 20);
    exp_id = 5'd31;
    check_id("wrap_down");
    hold(1, 1, 20);
    hold(0, 0, 20);
    check_id("both_cancel");

    // Random presses: short ones rejected, long ones step the index
    for (int n = 0; n < 12; n++) begin
      bit up;
      int len;
      up  = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 1) != 0) ? int'($urandom_range(12, 20)) : int'($urandom_range(1, 6));
      hold(up, !up, len);
      hold(0, 0, 20);
      if (len >= 12) exp_id = up ? exp_id + 5'd1 : exp_id - 5'd1;
      check_id("rand_press");
    end

    // Asynchronous reset mid-frame with a selection made and button still held
    btn_inc = 1'b1;
    org = ek + 13;
    exp_id = exp_id + 5'd1;
    goto(10);
    check_id("pre_reset_id");
    reset = 1'b0;
    #1;
    check("async_id",  32'(rif.reg_out_id), 32'd0);
    check("async_an",  32'(an_n),  32'hFE);
    check("async_seg", 32'(seg_n), 32'h40);
    check("async_dp",  32'(dp_n),  32'd0);
    tick();
    tick();
    reset = 1'b1;
    exp_id = 5'd0;
    hold(1, 0, 30);
    check_id("held_thru_reset");
    hold(0, 0, 20);
    hold(1, 0, 20);
    hold(0, 0, 20);
    exp_id = 5'd1;
    check_id("repress_after_reset");

    // Reset while the debouncer is arming
    btn_inc = 1'b1;
    repeat (5) tick();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    exp_id = 5'd0;
    hold(1, 0, 30);
    check_id("arm_reset_nopulse");
    hold(0, 0, 20);
    hold(1, 0, 20);
    hold(0, 0, 20);
    exp_id = 5'd1;
    check_id("arm_reset_repress");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
